// File: rtl/icache_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_fetch_ctrl_pkg;

  // Width of an instruction address bus.
  localparam int INST_ADDR_W = 32;
  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;

  // Bytes per instruction word; the byte assembly below assumes exactly four.
  localparam int FETCH_BYTES = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/icache_fetch_ctrl.sv
// Instruction fetch: icache hit returns next cycle, miss assembles a word from four byte reads.
// Latency: hit 1 cycle; miss 6 cycles minimum, +1 per grant gap or rdy=0 cycle.
// Backpressure: mem_gnt_i paces byte issue; rdy=0 freezes all state and drops mem_req_o.
module icache_fetch_ctrl
  import icache_fetch_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   req_i,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic                   flush_i,
  output logic                   inst_valid_o,
  output logic [31:0]            inst_o,
  output logic [INST_ADDR_W-1:0] inst_pc_o,
  output logic [INST_ADDR_W-1:0] ic_raddr_o,
  input  logic                   ic_hit_i,
  input  logic [31:0]            ic_inst_i,
  output logic                   ic_we_o,
  output logic [INST_ADDR_W-1:0] ic_waddr_o,
  output logic [31:0]            ic_winst_o,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic [7:0]             mem_rdata_i
);

  fetch_state_e state, state_nxt;

  inst_addr_bus_t miss_pc, miss_pc_nxt;
  logic [2:0]     issue_cnt, issue_cnt_nxt;
  logic [1:0]     recv_cnt, recv_cnt_nxt;
  logic           pending, pending_nxt;
  logic [23:0]    byte_buf, byte_buf_nxt;

  logic           inst_valid_nxt;
  logic [31:0]    inst_nxt;
  inst_addr_bus_t inst_pc_nxt;
  logic           ic_we_nxt;
  inst_addr_bus_t ic_waddr_nxt;
  logic [31:0]    ic_winst_nxt;

  logic           gnt_take;
  logic [31:0]    word;

  // The icache lookup is purely combinational on the live PC.
  assign ic_raddr_o = pc_i;

  // Issue bytes in order; the address wraps naturally at 2^32.
  assign mem_req_o  = rdy && (state == ST_FETCH) && (issue_cnt < 3'(FETCH_BYTES));
  assign mem_addr_o = miss_pc + INST_ADDR_W'(issue_cnt);
  assign gnt_take   = mem_req_o && mem_gnt_i;

  // The last byte lands straight from the bus; the lower three come from the buffer.
  assign word = {mem_rdata_i, byte_buf};

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_nxt      = state;
    miss_pc_nxt    = miss_pc;
    issue_cnt_nxt  = issue_cnt;
    recv_cnt_nxt   = recv_cnt;
    pending_nxt    = pending;
    byte_buf_nxt   = byte_buf;
    inst_valid_nxt = 1'b0;
    inst_nxt       = inst_o;
    inst_pc_nxt    = inst_pc_o;
    ic_we_nxt      = 1'b0;
    ic_waddr_nxt   = ic_waddr_o;
    ic_winst_nxt   = ic_winst_o;

    if (rdy) begin
      if (flush_i) begin
        // Redirect wins over hit and completion; any byte still in flight is dropped.
        state_nxt     = ST_IDLE;
        issue_cnt_nxt = '0;
        recv_cnt_nxt  = '0;
        pending_nxt   = 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_i) begin
              if (ic_hit_i) begin
                inst_valid_nxt = 1'b1;
                inst_nxt       = ic_inst_i;
                inst_pc_nxt    = pc_i;
              end else begin
                miss_pc_nxt   = pc_i;
                issue_cnt_nxt = '0;
                recv_cnt_nxt  = '0;
                pending_nxt   = 1'b0;
                state_nxt     = ST_FETCH;
              end
            end
          end
          ST_FETCH: begin
            if (gnt_take) begin
              issue_cnt_nxt = issue_cnt + 3'd1;
            end
            pending_nxt = gnt_take;
            if (pending) begin
              if (recv_cnt == 2'd3) begin
                inst_valid_nxt = 1'b1;
                inst_nxt       = word;
                inst_pc_nxt    = miss_pc;
                ic_we_nxt      = 1'b1;
                ic_waddr_nxt   = miss_pc;
                ic_winst_nxt   = word;
                issue_cnt_nxt  = '0;
                recv_cnt_nxt   = '0;
                pending_nxt    = 1'b0;
                state_nxt      = ST_IDLE;
              end else begin
                byte_buf_nxt[{recv_cnt, 3'b000} +: 8] = mem_rdata_i;
                recv_cnt_nxt = recv_cnt + 2'd1;
              end
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // State, counters, buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      miss_pc      <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      pending      <= 1'b0;
      byte_buf     <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      ic_we_o      <= 1'b0;
      ic_waddr_o   <= '0;
      ic_winst_o   <= '0;
    end else begin
      state        <= state_nxt;
      miss_pc      <= miss_pc_nxt;
      issue_cnt    <= issue_cnt_nxt;
      recv_cnt     <= recv_cnt_nxt;
      pending      <= pending_nxt;
      byte_buf     <= byte_buf_nxt;
      inst_valid_o <= inst_valid_nxt;
      inst_o       <= inst_nxt;
      inst_pc_o    <= inst_pc_nxt;
      ic_we_o      <= ic_we_nxt;
      ic_waddr_o   <= ic_waddr_nxt;
      ic_winst_o   <= ic_winst_nxt;
    end
  end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl with a small icache and byte-memory environment.
// Latency: checks hit, miss, grant-gap, flush, stall and reset timing cycle by cycle.
// Backpressure: grants and rdy are driven per cycle from the scenario tasks.
module tb_icache_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] ic_raddr_o;
  logic        ic_hit_i;
  logic [31:0] ic_inst_i;
  logic        ic_we_o;
  logic [31:0] ic_waddr_o;
  logic [31:0] ic_winst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] gnt_log[$];

  icache_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .req_i        (req_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .ic_raddr_o   (ic_raddr_o),
    .ic_hit_i     (ic_hit_i),
    .ic_inst_i    (ic_inst_i),
    .ic_we_o      (ic_we_o),
    .ic_waddr_o   (ic_waddr_o),
    .ic_winst_o   (ic_winst_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  // ---------------- environment: icache ----------------
  logic [31:0] ic_tag [64];
  logic [31:0] ic_dat [64];
  logic [63:0] ic_v = '0;

  function automatic int ic_idx(input logic [31:0] a);
    return int'({a[14:12], a[4:2]});
  endfunction

  // Lines that are resident before the run starts.
  function automatic logic [32:0] pre_lookup(input logic [31:0] a);
    case (a)
      32'h0000_1000: return {1'b1, 32'h0050_0093};
      32'h0000_1004: return {1'b1, 32'h1111_1111};
      32'h0000_1008: return {1'b1, 32'h2222_2222};
      default:       return '0;
    endcase
  endfunction

  always_comb begin
    logic [32:0] pre;
    int          idx;
    ic_hit_i  = 1'b0;
    ic_inst_i = '0;
    idx       = ic_idx(ic_raddr_o);
    pre       = pre_lookup(ic_raddr_o);
    if (ic_we_o && (ic_waddr_o == ic_raddr_o)) begin
      ic_hit_i  = 1'b1;
      ic_inst_i = ic_winst_o;
    end else if (ic_v[idx] && (ic_tag[idx] == ic_raddr_o)) begin
      ic_hit_i  = 1'b1;
      ic_inst_i = ic_dat[idx];
    end else if (pre[32]) begin
      ic_hit_i  = 1'b1;
      ic_inst_i = pre[31:0];
    end
  end

  always @(posedge clk) begin
    if (ic_we_o) begin
      ic_v[ic_idx(ic_waddr_o)]   <= 1'b1;
      ic_tag[ic_idx(ic_waddr_o)] <= ic_waddr_o;
      ic_dat[ic_idx(ic_waddr_o)] <= ic_winst_o;
    end
  end

  // ---------------- environment: byte memory ----------------
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    case (a[15:12])
      4'h2, 4'h5: w = 32'h00A0_0513;
      4'h3:       w = 32'h0010_0093;
      4'h4:       w = 32'hDDCC_BBAA;
      default:    w = 32'h4342_4140;
    endcase
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  always @(posedge clk) begin
    if (rdy && mem_req_o && mem_gnt_i) begin
      mem_rdata_i <= mem_byte(mem_addr_o);
      gnt_log.push_back(mem_addr_o);
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({inst_valid_o, ic_we_o, mem_req_o, inst_o, inst_pc_o, ic_waddr_o, ic_winst_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b we=%0b req=%0b inst=%h pc=%h waddr=%h winst=%h, required all 0",
               inst_valid_o, ic_we_o, mem_req_o, inst_o, inst_pc_o, ic_waddr_o, ic_winst_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({inst_valid_o, mem_req_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release_idle: valid=%0b req=%0b, required 0 0", inst_valid_o, mem_req_o);
    end
  endtask

  task automatic test_hit;
    @(negedge clk);
    req_i = 1'b1;
    pc_i  = 32'h0000_1000;
    @(negedge clk);
    req_i = 1'b0;
    #1;
    vectors++;
    if ({inst_valid_o, inst_o, inst_pc_o, ic_we_o} !== {1'b1, 32'h0050_0093, 32'h0000_1000, 1'b0}) begin
      miscompares++;
      $display("FAIL hit: valid=%0b inst=%h pc=%h we=%0b, required 1 00500093 00001000 0",
               inst_valid_o, inst_o, inst_pc_o, ic_we_o);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (inst_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_pulse: valid=%0b one cycle later, required 0", inst_valid_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pcs [3];
    logic [31:0] exp [3];
    pcs = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
    exp = '{32'h0050_0093, 32'h1111_1111, 32'h2222_2222};
    @(negedge clk);
    req_i = 1'b1;
    pc_i  = pcs[0];
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) pc_i = pcs[k];
      else       req_i = 1'b0;
      #1;
      vectors++;
      if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, exp[k-1], pcs[k-1]}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: valid=%0b inst=%h pc=%h, required 1 %h %h",
                 k, inst_valid_o, inst_o, inst_pc_o, exp[k-1], pcs[k-1]);
      end
    end
  endtask

  task automatic test_miss;
    @(negedge clk);
    req_i     = 1'b1;
    pc_i      = 32'h0000_2000;
    mem_gnt_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_i = (k == 6);
      #1;
      vectors++;
      if ((mem_req_o !== (k <= 4)) || ((k <= 4) && (mem_addr_o !== 32'(32'h2000 + k - 1)))) begin
        miscompares++;
        $display("FAIL miss_issue[%0d]: req=%0b addr=%h, required req=%0b addr=%h",
                 k, mem_req_o, mem_addr_o, (k <= 4), 32'(32'h2000 + k - 1));
      end
      vectors++;
      if (k == 6) begin
        if ({inst_valid_o, inst_o, inst_pc_o, ic_we_o, ic_waddr_o, ic_winst_o} !==
            {1'b1, 32'h00A0_0513, 32'h0000_2000, 1'b1, 32'h0000_2000, 32'h00A0_0513}) begin
          miscompares++;
          $display("FAIL miss_deliver: valid=%0b inst=%h pc=%h we=%0b waddr=%h winst=%h, required 1 00a00513 00002000 1 00002000 00a00513",
                   inst_valid_o, inst_o, inst_pc_o, ic_we_o, ic_waddr_o, ic_winst_o);
        end
      end else if (k == 7) begin
        if ({inst_valid_o, inst_o, inst_pc_o, ic_we_o} !== {1'b1, 32'h00A0_0513, 32'h0000_2000, 1'b0}) begin
          miscompares++;
          $display("FAIL miss_rerequest_hit: valid=%0b inst=%h pc=%h we=%0b, required 1 00a00513 00002000 0",
                   inst_valid_o, inst_o, inst_pc_o, ic_we_o);
        end
      end else if ({inst_valid_o, ic_we_o} !== 2'b00) begin
        miscompares++;
        $display("FAIL miss_quiet[%0d]: valid=%0b we=%0b, required 0 0", k, inst_valid_o, ic_we_o);
      end
    end
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_grant_gaps;
    logic [9:0] gpat;
    int         base;
    gpat = 10'b00_0101_0110;
    base = gnt_log.size();
    @(negedge clk);
    req_i = 1'b1;
    pc_i  = 32'h0000_5000;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      req_i     = 1'b0;
      mem_gnt_i = gpat[k];
      #1;
      vectors++;
      if (k == 8) begin
        if ({inst_valid_o, inst_o, inst_pc_o, ic_we_o} !== {1'b1, 32'h00A0_0513, 32'h0000_5000, 1'b1}) begin
          miscompares++;
          $display("FAIL gap_deliver: valid=%0b inst=%h pc=%h we=%0b, required 1 00a00513 00005000 1",
                   inst_valid_o, inst_o, inst_pc_o, ic_we_o);
        end
      end else if ({inst_valid_o, ic_we_o} !== 2'b00) begin
        miscompares++;
        $display("FAIL gap_quiet[%0d]: valid=%0b we=%0b, required 0 0", k, inst_valid_o, ic_we_o);
      end
    end
    mem_gnt_i = 1'b0;
    vectors++;
    if (gnt_log.size() !== base + 4) begin
      miscompares++;
      $display("FAIL gap_grant_count: %0d grants, required 4", gnt_log.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (gnt_log[base + i] !== 32'(32'h5000 + i)) begin
          miscompares++;
          $display("FAIL gap_addr[%0d]: %h, required %h", i, gnt_log[base + i], 32'(32'h5000 + i));
        end
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] exp_log [7];
    int          base;
    exp_log = '{32'h4000, 32'h4001, 32'h4002, 32'h3000, 32'h3001, 32'h3002, 32'h3003};
    base = gnt_log.size();
    @(negedge clk);
    req_i     = 1'b1;
    pc_i      = 32'h0000_4000;
    mem_gnt_i = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      flush_i = (k == 3);
      req_i   = (k == 4);
      if (k == 4) pc_i = 32'h0000_3000;
      #1;
      if (k == 4) begin
        vectors++;
        if (mem_req_o !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_idle_req: req=%0b after flush, required 0", mem_req_o);
        end
      end
      if (k == 5) begin
        vectors++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_3000}) begin
          miscompares++;
          $display("FAIL flush_new_issue: req=%0b addr=%h, required 1 00003000", mem_req_o, mem_addr_o);
        end
      end
      vectors++;
      if (k == 10) begin
        if ({inst_valid_o, inst_o, inst_pc_o, ic_we_o, ic_waddr_o, ic_winst_o} !==
            {1'b1, 32'h0010_0093, 32'h0000_3000, 1'b1, 32'h0000_3000, 32'h0010_0093}) begin
          miscompares++;
          $display("FAIL flush_refetch: valid=%0b inst=%h pc=%h we=%0b waddr=%h winst=%h, required 1 00100093 00003000 1 00003000 00100093",
                   inst_valid_o, inst_o, inst_pc_o, ic_we_o, ic_waddr_o, ic_winst_o);
        end
      end else if ({inst_valid_o, ic_we_o} !== 2'b00) begin
        miscompares++;
        $display("FAIL flush_quiet[%0d]: valid=%0b we=%0b, required 0 0", k, inst_valid_o, ic_we_o);
      end
    end
    mem_gnt_i = 1'b0;
    vectors++;
    if (gnt_log.size() !== base + 7) begin
      miscompares++;
      $display("FAIL flush_grant_count: %0d grants, required 7", gnt_log.size() - base);
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (gnt_log[base + i] !== exp_log[i]) begin
          miscompares++;
          $display("FAIL flush_addr[%0d]: %h, required %h", i, gnt_log[base + i], exp_log[i]);
        end
      end
    end
  endtask

  task automatic test_rdy_stall;
    logic exp_req;
    @(negedge clk);
    req_i     = 1'b1;
    pc_i      = 32'h0000_6000;
    mem_gnt_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_i = 1'b0;
      rdy   = !(k >= 3 && k <= 5);
      #1;
      exp_req = (k == 1) || (k == 2) || (k == 6) || (k == 7);
      vectors++;
      if (mem_req_o !== exp_req) begin
        miscompares++;
        $display("FAIL stall_req[%0d]: req=%0b, required %0b", k, mem_req_o, exp_req);
      end
      if (k == 6) begin
        vectors++;
        if (mem_addr_o !== 32'h0000_6002) begin
          miscompares++;
          $display("FAIL stall_resume_addr: %h, required 00006002", mem_addr_o);
        end
      end
      vectors++;
      if (k == 9) begin
        if ({inst_valid_o, inst_o, inst_pc_o, ic_we_o, ic_waddr_o} !==
            {1'b1, 32'h4342_4140, 32'h0000_6000, 1'b1, 32'h0000_6000}) begin
          miscompares++;
          $display("FAIL stall_deliver: valid=%0b inst=%h pc=%h we=%0b waddr=%h, required 1 43424140 00006000 1 00006000",
                   inst_valid_o, inst_o, inst_pc_o, ic_we_o, ic_waddr_o);
        end
      end else if ({inst_valid_o, ic_we_o} !== 2'b00) begin
        miscompares++;
        $display("FAIL stall_quiet[%0d]: valid=%0b we=%0b, required 0 0", k, inst_valid_o, ic_we_o);
      end
    end
    mem_gnt_i = 1'b0;
    rdy       = 1'b1;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    req_i     = 1'b1;
    pc_i      = 32'h0000_7000;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    #2;
    vectors++;
    if (mem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_prefetch: req=%0b mid-fetch, required 1", mem_req_o);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({inst_valid_o, ic_we_o, mem_req_o, inst_o, inst_pc_o, ic_waddr_o, ic_winst_o} !== '0) begin
      miscompares++;
      $display("FAIL areset_immediate: valid=%0b we=%0b req=%0b inst=%h pc=%h waddr=%h winst=%h, required all 0",
               inst_valid_o, ic_we_o, mem_req_o, inst_o, inst_pc_o, ic_waddr_o, ic_winst_o);
    end
    @(negedge clk);
    rst       = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_idle: req=%0b after release, required 0", mem_req_o);
    end
    req_i = 1'b1;
    pc_i  = 32'h0000_1000;
    @(negedge clk);
    req_i     = 1'b0;
    mem_gnt_i = 1'b0;
    #1;
    vectors++;
    if ({inst_valid_o, inst_o} !== {1'b1, 32'h0050_0093}) begin
      miscompares++;
      $display("FAIL areset_hit_after: valid=%0b inst=%h, required 1 00500093", inst_valid_o, inst_o);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_back_to_back();
    test_miss();
    test_grant_gaps();
    test_flush();
    test_rdy_stall();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
